// File: rtl/i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : i2s_tx
// Function : I2S master serializer with a single-entry stereo holding buffer.
//            Optional macro I2S_TX_MUTE_ON_UNDERRUN_EN silences underrun frames.
// Revision : 1.0
// ============================================================================
module i2s_tx #(
    parameter int BCLK_DIV = 8,
    parameter int WIDTH    = 16
) (
    input  logic             clk_sys,
    input  logic             RESET,
    input  logic [WIDTH-1:0] l_in,
    input  logic [WIDTH-1:0] r_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             i2s_bclk,
    output logic             i2s_ws,
    output logic             i2s_data,
    output logic             frame_start,
    output logic             underrun
);
    localparam int                  c_slot_w    = $clog2(2 * WIDTH);
    localparam int                  c_idx_w     = $clog2(WIDTH);
    localparam logic [7:0]          c_div_last  = 8'(BCLK_DIV - 1);
    localparam logic [c_slot_w-1:0] c_slot_last = c_slot_w'(2 * WIDTH - 1);
    localparam logic [c_slot_w-1:0] c_slot_half = c_slot_w'(WIDTH);

    logic [7:0]          div_cnt_q, div_cnt_d;
    logic                bclk_q, bclk_d;
    logic [c_slot_w-1:0] slot_q, slot_d;
    logic                ws_q, ws_d;
    logic                data_q, data_d;
    logic [WIDTH-1:0]    act_l_q, act_l_d;
    logic [WIDTH-1:0]    act_r_q, act_r_d;
    logic [WIDTH-1:0]    buf_l_q, buf_l_d;
    logic [WIDTH-1:0]    buf_r_q, buf_r_d;
    logic                full_q, full_d;

    logic                w_div_tc;
    logic                w_fe;
    logic                w_accept;
    logic [c_slot_w-1:0] w_slot_nxt;
    logic [c_idx_w-1:0]  w_l_idx;
    logic [c_idx_w-1:0]  w_r_idx;

    always_comb begin
        w_div_tc   = (div_cnt_q == c_div_last);
        w_fe       = w_div_tc & bclk_q;
        w_accept   = in_valid & ~full_q;
        w_slot_nxt = (slot_q == c_slot_last) ? '0 : slot_q + c_slot_w'(1);
        w_l_idx    = c_idx_w'(32'(WIDTH) - 32'(w_slot_nxt));
        w_r_idx    = c_idx_w'(32'(2 * WIDTH) - 32'(w_slot_nxt));

        div_cnt_d   = w_div_tc ? '0 : div_cnt_q + 8'd1;
        bclk_d      = bclk_q ^ w_div_tc;
        slot_d      = slot_q;
        ws_d        = ws_q;
        data_d      = data_q;
        act_l_d     = act_l_q;
        act_r_d     = act_r_q;
        buf_l_d     = buf_l_q;
        buf_r_d     = buf_r_q;
        full_d      = full_q;
        frame_start = 1'b0;
        underrun    = 1'b0;

        if (w_fe) begin
            slot_d = w_slot_nxt;
            ws_d   = (w_slot_nxt >= c_slot_half);
            // Slot 0 carries the LSB of the right word that is just finishing;
            // the active R register still holds it here, so it doubles as last_r.
            if (w_slot_nxt == '0) begin
                data_d = act_r_q[0];
            end else if (w_slot_nxt <= c_slot_half) begin
                data_d = act_l_q[w_l_idx];
            end else begin
                data_d = act_r_q[w_r_idx];
            end

            if (w_slot_nxt == '0) begin
                frame_start = 1'b1;
                if (full_q) begin
                    act_l_d = buf_l_q;
                    act_r_d = buf_r_q;
                    full_d  = 1'b0;
                end else begin
                    underrun = 1'b1;
`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
                    act_l_d = '0;
                    act_r_d = '0;
`endif
                end
            end
        end

        // Never bypasses into the active pair: a pair taken during an
        // underrun load waits for the following frame.
        if (w_accept) begin
            buf_l_d = l_in;
            buf_r_d = r_in;
            full_d  = 1'b1;
        end

        if (RESET) begin
            frame_start = 1'b0;
            underrun    = 1'b0;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            div_cnt_q <= '0;
            bclk_q    <= 1'b0;
            slot_q    <= '0;
            ws_q      <= 1'b0;
            data_q    <= 1'b0;
            act_l_q   <= '0;
            act_r_q   <= '0;
            buf_l_q   <= '0;
            buf_r_q   <= '0;
            full_q    <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            bclk_q    <= bclk_d;
            slot_q    <= slot_d;
            ws_q      <= ws_d;
            data_q    <= data_d;
            act_l_q   <= act_l_d;
            act_r_q   <= act_r_d;
            buf_l_q   <= buf_l_d;
            buf_r_q   <= buf_r_d;
            full_q    <= full_d;
        end
    end

    assign in_ready = ~full_q;
    assign i2s_bclk = bclk_q;
    assign i2s_ws   = ws_q;
    assign i2s_data = data_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_tx
// Function : Self-checking bench for i2s_tx against a frame-level stream model.
// Revision : 1.0
// ============================================================================
module tb_i2s_tx;
    localparam int BCLK_DIV = 2;
    localparam int WIDTH    = 16;

    logic        clk_sys  = 1'b0;
    logic        RESET    = 1'b1;
    logic [15:0] l_in     = '0;
    logic [15:0] r_in     = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        i2s_bclk;
    logic        i2s_ws;
    logic        i2s_data;
    logic        frame_start;
    logic        underrun;

    i2s_tx #(.BCLK_DIV(BCLK_DIV), .WIDTH(WIDTH)) dut (
        .clk_sys     (clk_sys),
        .RESET       (RESET),
        .l_in        (l_in),
        .r_in        (r_in),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .i2s_bclk    (i2s_bclk),
        .i2s_ws      (i2s_ws),
        .i2s_data    (i2s_data),
        .frame_start (frame_start),
        .underrun    (underrun)
    );

    always #5 clk_sys = ~clk_sys;

    int          n_assert      = 0;
    int          n_fail        = 0;
    int          cyc           = 0;
    int          m_slot        = 0;
    int          fe_total      = 0;
    int          last_fe_cyc   = -1;
    logic        first_pending = 1'b1;
    logic [31:0] q[$];
    logic [15:0] act_l         = '0;
    logic [15:0] act_r         = '0;
    logic [31:0] stream        = '0;
    logic        prev_bclk     = 1'b0;
    logic        seen_fs       = 1'b0;
    logic        seen_ur       = 1'b0;
    logic        fe_now        = 1'b0;
    logic        acc_now       = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clk_sys cycle; the model expects a frame to be the bit sequence
    // {last R LSB, L[15:0], R[15:1]} over slots 0..31.
    task automatic tick();
        logic        acc;
        logic        rst_e;
        logic [31:0] pair;
        logic        exp_fs;
        logic        exp_ur;
        logic        prev_r0;
        acc   = in_valid && in_ready && !RESET;
        rst_e = RESET;
        pair  = {l_in, r_in};
        @(posedge clk_sys);
        #1;
        cyc++;
        fe_now  = 1'b0;
        acc_now = acc;
        if (rst_e) begin
            m_slot        = 0;
            act_l         = '0;
            act_r         = '0;
            stream        = '0;
            q.delete();
            fe_total      = 0;
            last_fe_cyc   = -1;
            first_pending = 1'b1;
        end else begin
            if (prev_bclk && !i2s_bclk) begin
                fe_now = 1'b1;
                fe_total++;
                if (last_fe_cyc >= 0) chk("bclk_period", cyc - last_fe_cyc, 2 * BCLK_DIV);
                last_fe_cyc = cyc;
                m_slot      = (m_slot + 1) % 32;
            end
            exp_fs = fe_now && (m_slot == 0);
            exp_ur = exp_fs && (q.size() == 0);
            chk("frame_start", seen_fs, exp_fs);
            chk("underrun", seen_ur, exp_ur);
            if (exp_fs) begin
                if (first_pending) chk("first_frame_fe_count", fe_total, 32);
                first_pending = 1'b0;
                prev_r0 = act_r[0];
                if (q.size() != 0) begin
                    {act_l, act_r} = q.pop_front();
                end
`ifdef I2S_TX_MUTE_ON_UNDERRUN_EN
                else begin
                    act_l = '0;
                    act_r = '0;
                end
`endif
                stream = {prev_r0, act_l, act_r[15:1]};
            end
            chk("ws", i2s_ws, m_slot >= 16);
            chk("data", i2s_data, stream[31 - m_slot]);
            if (acc) q.push_back(pair);
        end
        prev_bclk = i2s_bclk;
        seen_fs   = frame_start;
        seen_ur   = underrun;
    endtask

    task automatic wait_slot(input int s);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(fe_now && m_slot == s) && n < 400);
        chk("wait_slot", fe_now && (m_slot == s), 1);
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r);
        int n;
        l_in     = l;
        r_in     = r;
        in_valid = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!acc_now && n < 400);
        chk("push_accepted", acc_now, 1);
        in_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_bclk", i2s_bclk, 0);
        chk("rst_ws", i2s_ws, 0);
        chk("rst_data", i2s_data, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_underrun", underrun, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) tick();
        chk_reset_outputs();
        RESET = 1'b0;

        // Frame 1 shifts zeros and underruns at the first wrap.
        wait_slot(0);
        push(16'hA5C3, 16'h8001);
        wait_slot(0);
        // Frame carrying A5C3/8001, then a starved frame.
        wait_slot(0);
        chk("starved_in_ready", in_ready, 1);

        // Offer a pair exactly in the slot-0 load cycle.
        n = 0;
        while (!frame_start && n < 400) begin
            tick();
            n++;
        end
        chk("race_frame_start", frame_start, 1);
        chk("race_underrun", underrun, 1);
        chk("race_in_ready", in_ready, 1);
        l_in     = 16'($urandom);
        r_in     = 16'($urandom);
        in_valid = 1'b1;
        tick();
        chk("race_accept", acc_now, 1);
        in_valid = 1'b0;
        wait_slot(0);

        // Back-pressure: second pair is held until the next load frees the buffer.
        push(16'($urandom), 16'($urandom));
        l_in     = 16'($urandom);
        r_in     = 16'($urandom);
        in_valid = 1'b1;
        n = 0;
        tick();
        while (!in_ready && n < 400) begin
            tick();
            n++;
        end
        chk("ready_rises_after_load", {30'd0, fe_now, m_slot == 0}, 32'd3);
        push(l_in, r_in);
        wait_slot(0);
        wait_slot(0);

        for (int k = 0; k < 3; k++) begin
            push(16'($urandom), 16'($urandom));
            wait_slot(0);
        end

        // Reset mid-frame with a pair buffered; the pair must be discarded.
        push(16'($urandom), 16'($urandom));
        chk("buffered_before_reset", in_ready, 0);
        wait_slot(9);
        RESET = 1'b1;
        tick();
        chk_reset_outputs();
        RESET = 1'b0;
        wait_slot(0);
        wait_slot(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
